// File: rtl/spi_master.sv
// spi_master: full-duplex SPI initiator, one DATA_WIDTH-bit frame per start, all four modes.
// Optional macro SPI_MASTER_LOOPBACK_EN adds a loopback input that feeds mosi back into the receiver.
module spi_master #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CLK_DIV    = 4,
    parameter bit          MSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  cpol,
    input  logic                  cpha,
`ifdef SPI_MASTER_LOOPBACK_EN
    input  logic                  loopback,
`endif
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  sclk,
    output logic                  cs_n,
    output logic                  mosi,
    input  logic                  miso
);

    localparam int unsigned DIV_W     = $clog2(CLK_DIV);
    localparam int unsigned LAST_EDGE = 2 * DATA_WIDTH;
    localparam int unsigned EDGE_W    = $clog2(LAST_EDGE + 1);
    localparam int unsigned BIT_W     = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SETUP, XFER, DONE} state_t;

    state_t                state_q, state_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [EDGE_W-1:0]     edge_q, edge_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_data_d;
    logic                  cpol_q, cpol_d, cpha_q, cpha_d;
    logic                  sclk_d, cs_n_d, mosi_d, busy_d, rx_valid_d;
    logic                  tick_c, drive_c, sample_c, rx_in_c;

    function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
        return MSB_FIRST ? w[DATA_WIDTH-1] : w[0];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] w);
        return MSB_FIRST ? {w[DATA_WIDTH-2:0], 1'b0} : {1'b0, w[DATA_WIDTH-1:1]};
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] w,
                                                       input logic b);
        return MSB_FIRST ? {w[DATA_WIDTH-2:0], b} : {b, w[DATA_WIDTH-1:1]};
    endfunction

`ifdef SPI_MASTER_LOOPBACK_EN
    logic lb_q, lb_d;
    assign rx_in_c = lb_q ? mosi : miso;
`else
    assign rx_in_c = miso;
`endif

    assign tick_c = (div_q == DIV_W'(CLK_DIV - 1));

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        edge_d     = edge_q;
        bit_d      = bit_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
`ifdef SPI_MASTER_LOOPBACK_EN
        lb_d       = lb_q;
`endif
        sclk_d     = sclk;
        cs_n_d     = cs_n;
        mosi_d     = mosi;
        busy_d     = busy;
        rx_data_d  = rx_data;
        rx_valid_d = 1'b0;
        drive_c    = 1'b0;
        sample_c   = 1'b0;

        unique case (state_q)
            IDLE: begin
                sclk_d = cpol;
                cs_n_d = 1'b1;
                mosi_d = 1'b0;
                busy_d = 1'b0;
                div_d  = '0;
                edge_d = '0;
                bit_d  = '0;
                if (start) begin
                    state_d = SETUP;
                    cpol_d  = cpol;
                    cpha_d  = cpha;
`ifdef SPI_MASTER_LOOPBACK_EN
                    lb_d    = loopback;
`endif
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    rx_sh_d = '0;
                    tx_sh_d = tx_data;
                    if (!cpha) begin
                        mosi_d  = first_bit(tx_data);
                        tx_sh_d = shift_out(tx_data);
                    end
                end
            end
            SETUP, XFER: begin
                div_d = tick_c ? '0 : div_q + DIV_W'(1);
                if (tick_c) begin
                    if (state_q == XFER && edge_q == EDGE_W'(LAST_EDGE)) begin
                        state_d    = DONE;
                        cs_n_d     = 1'b1;
                        mosi_d     = 1'b0;
                        rx_data_d  = rx_sh_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        state_d = XFER;
                        sclk_d  = ~sclk;
                        edge_d  = edge_q + EDGE_W'(1);
                        // Even edge count means the coming edge is a leading one
                        if (!edge_q[0]) begin
                            drive_c  = cpha_q;
                            sample_c = !cpha_q;
                        end else begin
                            sample_c = cpha_q;
                            drive_c  = !cpha_q && (edge_q != EDGE_W'(LAST_EDGE - 1));
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                sclk_d  = cpol_q;
                cs_n_d  = 1'b1;
                mosi_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        if (drive_c) begin
            mosi_d  = first_bit(tx_sh_q);
            tx_sh_d = shift_out(tx_sh_q);
        end
        if (sample_c && bit_q < BIT_W'(DATA_WIDTH)) begin
            rx_sh_d = shift_in(rx_sh_q, rx_in_c);
            bit_d   = bit_q + BIT_W'(1);
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            div_q    <= '0;
            edge_q   <= '0;
            bit_q    <= '0;
            tx_sh_q  <= '0;
            rx_sh_q  <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
`ifdef SPI_MASTER_LOOPBACK_EN
            lb_q     <= 1'b0;
`endif
            sclk     <= 1'b0;
            cs_n     <= 1'b1;
            mosi     <= 1'b0;
            busy     <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            edge_q   <= edge_d;
            bit_q    <= bit_d;
            tx_sh_q  <= tx_sh_d;
            rx_sh_q  <= rx_sh_d;
            cpol_q   <= cpol_d;
            cpha_q   <= cpha_d;
`ifdef SPI_MASTER_LOOPBACK_EN
            lb_q     <= lb_d;
`endif
            sclk     <= sclk_d;
            cs_n     <= cs_n_d;
            mosi     <= mosi_d;
            busy     <= busy_d;
            rx_data  <= rx_data_d;
            rx_valid <= rx_valid_d;
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: drives spi_master against a timing-formula reference of the SPI bus and a slave model.
// Loopback frames are exercised when SPI_MASTER_LOOPBACK_EN is defined.
module tb_spi_master;

    localparam int N      = 8;
    localparam int D      = 4;
`ifdef SPI_MASTER_LOOPBACK_EN
    localparam bit MSBF   = 1'b0;
`else
    localparam bit MSBF   = 1'b1;
`endif
    localparam int DONE_T = (2 * N + 1) * D + 1;
    localparam int TEND   = DONE_T + 1;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [N-1:0] tx_data;
    logic         cpol;
    logic         cpha;
`ifdef SPI_MASTER_LOOPBACK_EN
    logic         loopback;
`endif
    logic         busy;
    logic [N-1:0] rx_data;
    logic         rx_valid;
    logic         sclk;
    logic         cs_n;
    logic         mosi;
    logic         miso;

    int           checks = 0;
    int           errors = 0;
    int           cur_t  = 0;
    logic [N-1:0] last_rx = '0;

    spi_master #(.DATA_WIDTH(N), .CLK_DIV(D), .MSB_FIRST(MSBF)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .tx_data  (tx_data),
        .cpol     (cpol),
        .cpha     (cpha),
`ifdef SPI_MASTER_LOOPBACK_EN
        .loopback (loopback),
`endif
        .busy     (busy),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .sclk     (sclk),
        .cs_n     (cs_n),
        .mosi     (mosi),
        .miso     (miso)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0d observed=%0b expected=%0b", tag, cur_t, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, cur_t, obs, exp);
        end
    endtask

    // Number of sclk edges visible at offset t after the accept cycle
    function automatic int edges_at(input int t);
        int e;
        e = (t < 1) ? 0 : (t - 1) / D;
        if (e > 2 * N) e = 2 * N;
        return e;
    endfunction

    // j-th bit on the wire of word w
    function automatic logic bit_of(input logic [N-1:0] w, input int j);
        int k;
        if (j > N - 1) j = N - 1;
        k = MSBF ? (N - 1 - j) : j;
        return w[k];
    endfunction

    task automatic run_frame(input logic [N-1:0] tx, input logic [N-1:0] slv,
                             input logic pol, input logic pha, input logic lb,
                             input bit hold, input bit ign, input int stop_at);
        logic [N-1:0] exp_rx;
        logic         exp_mosi;
        int           e;
        int           last;
        exp_rx  = lb ? tx : slv;
        last    = (stop_at > 0) ? stop_at : TEND;
        tx_data = tx;
        cpol    = pol;
        cpha    = pha;
        start   = 1'b1;
        miso    = 1'($urandom);
`ifdef SPI_MASTER_LOOPBACK_EN
        loopback = lb;
`endif
        for (int t = 1; t <= last; t++) begin
            @(negedge clk);
            cur_t = t;
            if (!hold) start = 1'b0;
            e = edges_at(t);
            if (t == DONE_T) last_rx = exp_rx;
            if (t >= DONE_T)   exp_mosi = 1'b0;
            else if (pha)      exp_mosi = (e == 0) ? 1'b0 : bit_of(tx, (e - 1) / 2);
            else               exp_mosi = bit_of(tx, e / 2);
            chk1("cs_n", cs_n, (t < DONE_T) ? 1'b0 : 1'b1);
            chk1("busy", busy, (t <= DONE_T) ? 1'b1 : 1'b0);
            chk1("sclk", sclk, pol ^ 1'(e % 2));
            chk1("mosi", mosi, exp_mosi);
            chk1("rx_valid", rx_valid, (t == DONE_T) ? 1'b1 : 1'b0);
            chkw("rx_data", rx_data, last_rx);
            // Slave presents its next bit according to edges seen so far
            if (lb)                 miso = 1'($urandom);
            else if (pha)           miso = (e == 0) ? 1'($urandom) : bit_of(slv, (e - 1) / 2);
            else                    miso = bit_of(slv, e / 2);
            if (t >= 2 && t <= TEND - 2) begin
                tx_data = N'($urandom);
                cpol    = 1'($urandom);
                cpha    = 1'($urandom);
`ifdef SPI_MASTER_LOOPBACK_EN
                loopback = 1'($urandom);
`endif
            end
            if (t == TEND - 1) cpol = pol;
            if (ign && t == 20) begin
                start   = 1'b1;
                tx_data = '1;
            end
            if (ign && t == 21 && !hold) start = 1'b0;
        end
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cur_t = -1;
            chk1("idle_cs_n", cs_n, 1'b1);
            chk1("idle_busy", busy, 1'b0);
            chk1("idle_rx_valid", rx_valid, 1'b0);
            chk1("idle_sclk", sclk, cpol);
            chk1("idle_mosi", mosi, 1'b0);
            chkw("idle_rx_data", rx_data, last_rx);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        tx_data = '0;
        cpol    = 1'b0;
        cpha    = 1'b0;
        miso    = 1'b0;
`ifdef SPI_MASTER_LOOPBACK_EN
        loopback = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk1("rst_cs_n", cs_n, 1'b1);
        chk1("rst_sclk", sclk, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_rx_valid", rx_valid, 1'b0);
        chk1("rst_mosi", mosi, 1'b0);
        chkw("rst_rx_data", rx_data, '0);
        rst_n = 1'b1;
        cpol  = 1'b1;
        @(negedge clk);
        chk1("idle_follow_hi", sclk, 1'b1);
        cpol = 1'b0;
        @(negedge clk);
        chk1("idle_follow_lo", sclk, 1'b0);

        // Directed modes 0..3
        run_frame(8'h3C, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        idle_check(2);
        run_frame(8'h55, 8'hF0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        idle_check(2);
        run_frame(8'h99, 8'h12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        idle_check(2);
        run_frame(8'h42, 8'h77, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        idle_check(2);

        // start during a frame is ignored
        run_frame(N'($urandom), N'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b1, 0);
        idle_check(4);

        // Back-to-back with start held high
        for (int i = 0; i < 3; i++)
            run_frame(N'($urandom), N'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b1, 1'b0, 0);
        run_frame(N'($urandom), N'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0, 0);
        idle_check(4);

        // Randomized frames
        for (int i = 0; i < 8; i++) begin
            run_frame(N'($urandom), N'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0, 0);
            idle_check(1 + int'($urandom_range(0, 3)));
        end

`ifdef SPI_MASTER_LOOPBACK_EN
        run_frame(8'h01, N'($urandom), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        idle_check(2);
        for (int i = 0; i < 4; i++) begin
            run_frame(N'($urandom), N'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'b0, 1'b0, 0);
            idle_check(2);
        end
`endif

        // Asynchronous reset after three sclk edges
        run_frame(8'h3C, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1 + 3 * D);
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        cur_t = -2;
        chk1("mid_rst_cs_n", cs_n, 1'b1);
        chk1("mid_rst_sclk", sclk, 1'b0);
        chk1("mid_rst_busy", busy, 1'b0);
        chk1("mid_rst_rx_valid", rx_valid, 1'b0);
        chk1("mid_rst_mosi", mosi, 1'b0);
        chkw("mid_rst_rx_data", rx_data, '0);
        cpol = 1'b1;
        @(negedge clk);
        chk1("rst_hold_sclk", sclk, 1'b0);
        rst_n   = 1'b1;
        last_rx = '0;
        @(negedge clk);
        chk1("post_rst_sclk", sclk, 1'b1);
        chk1("post_rst_cs_n", cs_n, 1'b1);
        chk1("post_rst_busy", busy, 1'b0);
        idle_check(2);
        run_frame(N'($urandom), N'($urandom), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        idle_check(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Parameterised SPI master and the initiator counterpart of `spi_slave`. It drives `sclk`, `cs_n` and `mosi`, and samples `miso`, for one DATA_WIDTH-bit full-duplex frame per `start` pulse.
- All four SPI modes are selected by `cpol`/`cpha`, which are latched at `start`.
- Runs on one system clock. `sclk` is derived internally by a programmable divider.
- Sits between a host-side controller (register bank/DMA) and the off-chip or on-chip SPI bus.

Parameters:
- DATA_WIDTH, 8: frame length in bits. Minimum 2.
- CLK_DIV, 4: system-clock cycles per sclk half-period. Minimum 2.
- MSB_FIRST, 1: 1 = MSB shifted first on both mosi and miso; 0 = LSB first.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a frame. Accepted only when busy=0.
- tx_data  in  DATA_WIDTH  frame to transmit, latched when start is accepted.
- cpol  in  1  clock polarity, latched at start. In IDLE, sclk follows it.
- cpha  in  1  clock phase, latched at start.
- busy  out  1  high from the cycle after start is accepted until frame completion.
- rx_data  out  DATA_WIDTH  last received frame. Holds its value until the next completion.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- sclk  out  1  SPI clock, registered.
- cs_n  out  1  chip select, active low, registered.
- mosi  out  1  serial data out, registered.
- miso  in  1  serial data in.

Behaviour:
- Reset (asynchronous, at any time including mid-frame):
  - cs_n=1, sclk=0, mosi=0, busy=0, rx_valid=0, rx_data=0.
  - Shift registers, counters and latched mode cleared; state=IDLE.
- Definitions:
  - T = the cycle in which start=1 and busy=0 are seen.
  - Leading edge = sclk leaving its cpol level. Trailing edge = sclk returning to it.
- States: IDLE -> SETUP -> XFER -> DONE -> IDLE.
- IDLE:
  - cs_n=1; sclk tracks the cpol input each cycle; mosi holds 0.
  - start with busy=0: latch tx_data/cpol/cpha, go to SETUP.
- SETUP (entered at T+1, lasts CLK_DIV cycles):
  - cs_n=0 and busy=1 from T+1.
  - cpha=0: mosi = first bit from T+1.
  - cpha=1: mosi holds 0 until the first leading edge.
- XFER:
  - sclk toggles at T+1+k*CLK_DIV for k=1..2*DATA_WIDTH; the 2*DATA_WIDTH-th edge is the last.
  - cpha=0: leading edge samples miso; trailing edge drives the next mosi bit. No mosi change on the final trailing edge.
  - cpha=1: leading edge drives the mosi bit; trailing edge samples miso.
  - Sampling takes miso in the same clk cycle that the sclk register toggles, i.e. the value present before the edge.
  - Edge and bit counters: clog2-sized. Bit counter saturates at DATA_WIDTH.
- DONE (entered CLK_DIV cycles after the last edge, at T+1+(2*DATA_WIDTH+1)*CLK_DIV):
  - cs_n=1, mosi=0, rx_data<=received shift register, rx_valid=1 for that single cycle. busy is still 1.
  - Next cycle: IDLE, busy=0. A new start is accepted from then on.
- start while busy=1 is ignored (not queued).
- tx_data/cpol/cpha changes during a frame have no effect until the next accepted start.
- sclk always ends the frame at the latched cpol level; cs_n never rises while sclk is away from idle.
- Bit ordering follows MSB_FIRST identically for tx and rx.

Optional Feature:
- Macro: SPI_MASTER_LOOPBACK_EN.
- Defined:
  - Adds input port loopback (1 bit).
  - When loopback=1, the receive sampler uses the internal mosi register instead of the miso pin, so rx_data == tx_data after each frame in every mode.
  - The sclk/cs_n/mosi pins are still driven normally.
  - loopback is sampled only at start acceptance.
- Undefined: no loopback port; miso is always sampled.

Test Plan:
- Reset/idle:
  - Stimulus: rst_n=0 mid-frame (after 3 sclk edges), cpol=1.
  - Response: immediately cs_n=1, sclk=0, busy=0, rx_valid=0. After release, in IDLE, sclk=1 on the next clk.
- Mode 0 with `spi_slave` attached (tx_data=8'hA5):
  - Stimulus: master tx_data=8'h3C, CLK_DIV=4.
  - Response: cs_n low at T+1, first sclk rise at T+5, 16 edges ending T+65, cs_n high and rx_valid at T+69, busy low at T+70.
  - Slave rx_data=8'h3C; master rx_data=8'hA5.
- Modes 1/2/3 against `spi_slave`:
  - Stimulus: (8'h55 / slave 8'hF0), (8'h99 / slave 8'h12), (8'h42 / slave 8'h77).
  - Response: both sides receive exactly; sclk idles at cpol before and after each frame.
- Ignored start:
  - Stimulus: pulse start with tx_data=8'hFF at T+20 during a frame.
  - Response: frame unaffected, exactly one rx_valid, no second frame.
- Back-to-back:
  - Stimulus: hold start=1 continuously.
  - Response: next cs_n fall exactly 2 cycles after the previous cs_n rise (DONE, then IDLE accept).
  - One rx_valid pulse per frame, each one cycle long.
- MSB_FIRST=0 plus SPI_MASTER_LOOPBACK_EN:
  - Stimulus: loopback=1, tx_data=8'h01, mode 3.
  - Response: mosi shows 1 on the first driven bit, then 0s; rx_data=8'h01.
